// File: rtl/usb_rx_pid_decoder_if.sv
// usb_rx_pid_decoder_if: decoded bit stream in, PID/framing events and payload bits out
interface usb_rx_pid_decoder_if;
  logic       in_bit;
  logic       in_valid;
  logic       eop;
  logic       rec_start;
  logic       ACK_rec;
  logic       NAK_rec;
  logic       DATA0_rec;
  logic [3:0] pid;
  logic       out_bit;
  logic       out_sending;
  logic       payload_end;
  logic       pid_error;
  logic       frame_error;
  modport master (
    output in_bit, in_valid, eop,
    input  rec_start, ACK_rec, NAK_rec, DATA0_rec, pid, out_bit, out_sending,
           payload_end, pid_error, frame_error
  );
  modport slave (
    input  in_bit, in_valid, eop,
    output rec_start, ACK_rec, NAK_rec, DATA0_rec, pid, out_bit, out_sending,
           payload_end, pid_error, frame_error
  );
endinterface

// File: rtl/usb_rx_pid_decoder.sv
// usb_rx_pid_decoder: SYNC hunt, PID capture/validation and DATA0 payload forwarding
module usb_rx_pid_decoder #(
  parameter int SYNC_ZEROS       = 7,
  parameter int MAX_PAYLOAD_BITS = 80
) (
  input logic                  clock,
  input logic                  reset_n,
  usb_rx_pid_decoder_if.slave  bus
);
  localparam int ZW = $clog2(SYNC_ZEROS + 1);
  localparam int PW = $clog2(MAX_PAYLOAD_BITS + 1);
  typedef enum logic [2:0] {HUNT, PID, HS_EOP, DATA, WAIT_EOP} state_t;
  state_t        state, state_n;
  logic [ZW-1:0] zcnt, zcnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [7:0]    sr, sr_n, pid_byte;
  logic [2:0]    bcnt, bcnt_n;
  logic [3:0]    pid_n;
  logic          rec_start_n, ack_n, nak_n, data0_n, out_bit_n, out_sending_n;
  logic          payload_end_n, pid_error_n, frame_error_n, bit_ok;
  assign bit_ok   = bus.in_valid & ~bus.eop;
  assign pid_byte = {bus.in_bit, sr[7:1]};
  always_comb begin
    state_n       = state;
    zcnt_n        = zcnt;
    pcnt_n        = pcnt;
    sr_n          = sr;
    bcnt_n        = bcnt;
    pid_n         = bus.pid;
    out_bit_n     = bus.out_bit;
    rec_start_n   = 1'b0;
    ack_n         = 1'b0;
    nak_n         = 1'b0;
    data0_n       = 1'b0;
    out_sending_n = 1'b0;
    payload_end_n = 1'b0;
    pid_error_n   = 1'b0;
    frame_error_n = 1'b0;
    case (state)
      HUNT: if (bit_ok) begin
        if (!bus.in_bit) zcnt_n = (zcnt == ZW'(SYNC_ZEROS)) ? zcnt : zcnt + ZW'(1);
        else begin
          zcnt_n = '0;
          if (zcnt == ZW'(SYNC_ZEROS)) begin
            rec_start_n = 1'b1;
            bcnt_n      = '0;
            state_n     = PID;
          end
        end
      end
      PID: if (bus.eop) begin
        pid_error_n = 1'b1;
        state_n     = HUNT;
      end else if (bus.in_valid) begin
        sr_n   = pid_byte;
        bcnt_n = bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          state_n = WAIT_EOP;
          if (pid_byte[7:4] != ~pid_byte[3:0]) pid_error_n = 1'b1;
          else if (pid_byte == 8'hD2) begin
            ack_n   = 1'b1;
            pid_n   = 4'h2;
            state_n = HS_EOP;
          end else if (pid_byte == 8'h5A) begin
            nak_n   = 1'b1;
            pid_n   = 4'hA;
            state_n = HS_EOP;
          end else if (pid_byte == 8'hC3) begin
            data0_n = 1'b1;
            pid_n   = 4'h3;
            pcnt_n  = '0;
            state_n = DATA;
          end else pid_error_n = 1'b1;
        end
      end
      HS_EOP: if (bus.eop) state_n = HUNT;
      else if (bus.in_valid) begin
        frame_error_n = 1'b1;
        state_n       = WAIT_EOP;
      end
      DATA: if (bus.eop) begin
        payload_end_n = 1'b1;
        state_n       = HUNT;
      end else if (bus.in_valid) begin
        if (pcnt == PW'(MAX_PAYLOAD_BITS)) begin
          frame_error_n = 1'b1;
          state_n       = WAIT_EOP;
        end else begin
          out_bit_n     = bus.in_bit;
          out_sending_n = 1'b1;
          pcnt_n        = pcnt + PW'(1);
        end
      end
      WAIT_EOP: if (bus.eop) state_n = HUNT;
      default: state_n = HUNT;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= HUNT;
      zcnt            <= '0;
      pcnt            <= '0;
      sr              <= '0;
      bcnt            <= '0;
      bus.pid         <= 4'h0;
      bus.out_bit     <= 1'b0;
      bus.rec_start   <= 1'b0;
      bus.ACK_rec     <= 1'b0;
      bus.NAK_rec     <= 1'b0;
      bus.DATA0_rec   <= 1'b0;
      bus.out_sending <= 1'b0;
      bus.payload_end <= 1'b0;
      bus.pid_error   <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      state           <= state_n;
      zcnt            <= zcnt_n;
      pcnt            <= pcnt_n;
      sr              <= sr_n;
      bcnt            <= bcnt_n;
      bus.pid         <= pid_n;
      bus.out_bit     <= out_bit_n;
      bus.rec_start   <= rec_start_n;
      bus.ACK_rec     <= ack_n;
      bus.NAK_rec     <= nak_n;
      bus.DATA0_rec   <= data0_n;
      bus.out_sending <= out_sending_n;
      bus.payload_end <= payload_end_n;
      bus.pid_error   <= pid_error_n;
      bus.frame_error <= frame_error_n;
    end
  end
endmodule

// File: tb/tb_usb_rx_pid_decoder.sv
// tb_usb_rx_pid_decoder: vector table for packet decoding plus directed payload/reset sequences
module tb_usb_rx_pid_decoder;
  localparam logic [7:0] RS = 8'h80, ACK = 8'h40, NAK = 8'h20, D0 = 8'h10;
  localparam logic [7:0] PE = 8'h08, FE = 8'h04, PEND = 8'h02, OS = 8'h01;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  usb_rx_pid_decoder_if bus();
  usb_rx_pid_decoder #(.SYNC_ZEROS(7), .MAX_PAYLOAD_BITS(80)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic        b;
    logic        v;
    logic        e;
    logic [11:0] exp;
  } vec_t;
  vec_t        tbl[$];
  int          checks = 0, fails = 0, send_cnt = 0, vec_id = 0;
  logic [3:0]  cur_pid = 4'h0;
  logic [11:0] obs;
  assign obs = {bus.rec_start, bus.ACK_rec, bus.NAK_rec, bus.DATA0_rec, bus.pid_error,
                bus.frame_error, bus.payload_end, bus.out_sending, bus.pid};
  always @(negedge clock) if (bus.out_sending) send_cnt++;
  function automatic logic [11:0] mk(input logic [7:0] f);
    return {f, cur_pid};
  endfunction
  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step(input logic b, input logic v, input logic e, input logic [11:0] exp, input string name);
    bus.in_bit   = b;
    bus.in_valid = v;
    bus.eop      = e;
    @(posedge clock);
    #1;
    check(name, obs, exp);
  endtask
  task automatic add(input logic b, input logic v, input logic e, input logic [7:0] f);
    vec_t r;
    r.b   = b;
    r.v   = v;
    r.e   = e;
    r.exp = mk(f);
    tbl.push_back(r);
  endtask
  task automatic add_sync(input int zeros, input logic ok);
    repeat (zeros) add(1'b0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, ok ? RS : 8'h00);
  endtask
  task automatic add_pid(input logic [7:0] p, input logic [7:0] f, input logic [3:0] np);
    for (int i = 0; i < 7; i++) add(p[i], 1'b1, 1'b0, 8'h00);
    cur_pid = np;
    add(p[7], 1'b1, 1'b0, f);
  endtask
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].v, tbl[i].e, tbl[i].exp, $sformatf("%s_vec%0d", tag, vec_id));
      vec_id++;
    end
    tbl.delete();
  endtask
  task automatic payload(input int n, input logic gapped);
    int k = 0;
    int c = 0;
    logic b;
    while (k < n) begin
      if (gapped && (c % 3 == 2)) step(1'b1, 1'b0, 1'b0, mk(8'h00), "pay_gap");
      else begin
        b = (k % 2 == 0);
        step(b, 1'b1, 1'b0, mk(OS), "pay_send");
        check("pay_out_bit", 12'(bus.out_bit), 12'(b));
        k++;
      end
      c++;
    end
  endtask
  initial begin
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.eop      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", obs, 12'h000);
    reset_n = 1'b1;
    add_sync(7, 1'b1); add_pid(8'hD2, ACK, 4'h2); add(1, 1, 1, 8'h00);
    add(0, 0, 1, 8'h00);
    add_sync(7, 1'b1); add_pid(8'h52, PE, cur_pid);
    add(1, 1, 0, 8'h00); add(0, 1, 0, 8'h00); add(1, 1, 0, 8'h00); add(0, 0, 1, 8'h00);
    add_sync(9, 1'b1); add_pid(8'h5A, NAK, 4'hA); add(0, 0, 1, 8'h00);
    add_sync(7, 1'b1); add_pid(8'hD2, ACK, 4'h2);
    add(1, 1, 0, FE); add(0, 1, 0, 8'h00); add(0, 0, 1, 8'h00); add(0, 0, 0, 8'h00);
    add_sync(7, 1'b1); add_pid(8'hE1, PE, cur_pid); add(0, 1, 0, 8'h00); add(0, 0, 1, 8'h00);
    add_sync(7, 1'b1); add(1, 1, 0, 8'h00); add(0, 1, 0, 8'h00); add(0, 0, 0, 8'h00);
    add(1, 1, 0, 8'h00); add(0, 0, 1, PE);
    add_sync(5, 1'b0);
    for (int i = 0; i < 8; i++) add(8'hD2 >> i, 1'b1, 1'b0, 8'h00);
    add(0, 0, 1, 8'h00);
    add_sync(7, 1'b1); add_pid(8'hC3, D0, 4'h3); add(0, 0, 1, PEND);
    run_tbl("table");
    add_sync(7, 1'b1); add_pid(8'hC3, D0, 4'h3);
    run_tbl("d0_gap");
    send_cnt = 0;
    payload(80, 1'b1);
    step(1'b0, 1'b0, 1'b1, mk(PEND), "d0_gap_eop");
    step(1'b0, 1'b0, 1'b0, mk(8'h00), "d0_gap_idle");
    check("d0_gap_send_count", 12'(send_cnt), 12'd80);
    add_sync(7, 1'b1); add_pid(8'hC3, D0, 4'h3);
    run_tbl("d0_over");
    send_cnt = 0;
    payload(80, 1'b0);
    step(1'b1, 1'b1, 1'b0, mk(FE), "d0_over_81st");
    step(1'b0, 1'b1, 1'b0, mk(8'h00), "d0_over_ignored");
    step(1'b0, 1'b0, 1'b1, mk(8'h00), "d0_over_eop");
    check("d0_over_send_count", 12'(send_cnt), 12'd80);
    add_sync(7, 1'b1); add_pid(8'hC3, D0, 4'h3);
    run_tbl("rst_mid");
    payload(20, 1'b0);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", obs, 12'h000);
    check("async_reset_out_bit", 12'(bus.out_bit), 12'd0);
    cur_pid = 4'h0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    add_sync(7, 1'b1); add_pid(8'hD2, ACK, 4'h2); add(0, 0, 1, 8'h00);
    add_sync(5, 1'b0); add(0, 0, 1, 8'h00);
    run_tbl("after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
